// File: rtl/serial_fa_ctrl.sv
// rtl/serial_fa_ctrl.sv - bit-serial add/subtract controller around one 1-bit full adder
module serial_fa_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_c;
  logic last_step;

  // The single shared full-adder cell.
  assign fa_s      = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign fa_c      = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign last_step = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && start) begin
      // Subtraction is A + ~B + 1, so the inversion and the +1 happen at load.
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      res_d   = {fa_s, res_q[W-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CW'(1);
      if (last_step) begin
        // carry_q here is the carry into the MSB; fa_c is the carry out of it.
        sum_d  = {fa_s, res_q[W-1:1]};
        cout_d = fa_c;
        ovf_d  = carry_q ^ fa_c;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_fa_ctrl.sv
// tb/tb_serial_fa_ctrl.sv - directed table and exhaustive small-width checks for serial_fa_ctrl
module tb_serial_fa_ctrl;

  localparam int W8 = 8;
  localparam int W3 = 3;
  localparam int W5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       startx, cinx, subx;
  logic [2:0] a3, b3, sum3;
  logic       busy3, done3, cout3, ovf3;
  logic [4:0] a5, b5, sum5;
  logic       busy5, done5, cout5, ovf5;

  serial_fa_ctrl #(.W(W8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );
  serial_fa_ctrl #(.W(W3)) u_dut3 (
    .clk(clk), .rst(rst), .start(startx), .a(a3), .b(b3), .cin(cinx), .sub(subx),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .overflow(ovf3)
  );
  serial_fa_ctrl #(.W(W5)) u_dut5 (
    .clk(clk), .rst(rst), .start(startx), .a(a5), .b(b5), .cin(cinx), .sub(subx),
    .busy(busy5), .done(done5), .sum(sum5), .cout(cout5), .overflow(ovf5)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl[10];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {cout, overflow, sum} from plain integer arithmetic.
  function automatic logic [31:0] model(input int w, input int a, input int b, input logic c, input logic s);
    int m, r, sa, sb, sr;
    bit ov;
    m  = (1 << w) - 1;
    r  = s ? a + ((~b) & m) + 1 : a + b + int'(c);
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr = s ? sa - sb : sa + sb + int'(c);
    ov = (sr > (m >> 1)) || (sr < -(1 << (w - 1)));
    return 32'((((r >> w) & 1) << (w + 1)) | (int'(ov) << w) | (r & m));
  endfunction

  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                      output int lat, output int ndone, output int nbusy);
    logic [7:0] prev;
    prev   = sum8;
    a8     = a;
    b8     = b;
    cin8   = c;
    sub8   = s;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8     = ~a;
    b8     = a ^ b;
    cin8   = ~c;
    sub8   = ~s;
    lat    = -1;
    ndone  = 0;
    nbusy  = 0;
    for (int i = 0; i < W8 + 3; i++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (i == W8 - 1) chk("sum_hold_during_run", 32'(sum8), 32'(prev));
      if (i == W8) chk("busy_low_at_done", 32'(busy8), 32'd0);
    end
  endtask

  task automatic lanes(input int a, input int b, input logic c, input logic s);
    int l3, l5;
    a5     = 5'(a);
    b5     = 5'(b);
    a3     = 3'(a);
    b3     = 3'(b);
    cinx   = c;
    subx   = s;
    startx = 1'b1;
    @(posedge clk);
    #1;
    startx = 1'b0;
    a5     = ~a5;
    b5     = b5 ^ 5'h15;
    a3     = ~a3;
    cinx   = ~c;
    subx   = ~s;
    l3 = -1;
    l5 = -1;
    for (int i = 0; i < W5 + 2; i++) begin
      @(negedge clk);
      if (done3 && l3 < 0) l3 = i;
      if (done5 && l5 < 0) l5 = i;
    end
    chk("w3_result", 32'({cout3, ovf3, sum3}), model(W3, a & 7, b & 7, c, s));
    chk("w3_latency", 32'(l3), 32'(W3));
    chk("w5_result", 32'({cout5, ovf5, sum5}), model(W5, a, b, c, s));
    chk("w5_latency", 32'(l5), 32'(W5));
  endtask

  initial begin
    int lat, nd, nb;

    tbl[0] = '{8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[9] = '{8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    startx = 1'b0; a3 = '0; b3 = '0; a5 = '0; b5 = '0; cinx = 1'b0; subx = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy8, done8, sum8, cout8, ovf8}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat, nd, nb);
      chk($sformatf("vec%0d_sum", i), 32'(sum8), 32'(tbl[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(cout8), 32'(tbl[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf8), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W8));
      chk($sformatf("vec%0d_done_width", i), 32'(nd), 32'd1);
    end

    // Second start mid-run must be ignored and must not extend busy.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat = -1; nd = 0; nb = 0;
    for (int i = 0; i < W8 + 4; i++) begin
      @(negedge clk);
      if (i == 2) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      if (i == 3) begin start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; end
      if (busy8) nb++;
      if (done8) begin
        nd++;
        if (lat < 0) lat = i;
      end
    end
    chk("ignore_start_sum", 32'(sum8), 32'h02);
    chk("ignore_start_latency", 32'(lat), 32'(W8));
    chk("ignore_start_busy_cycles", 32'(nb), 32'(W8));
    chk("ignore_start_done_count", 32'(nd), 32'd1);

    run8(8'h80, 8'h01, 1'b0, 1'b1, lat, nd, nb);
    chk("pre_reset_flags", 32'({sum8, cout8, ovf8}), 32'h1FF);

    // Reset in the middle of a run, with start held across the reset edge.
    a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", 32'({busy8, done8, sum8, cout8, ovf8}), 32'd0);
    rst = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    chk("start_with_reset_dropped", 32'({busy8, done8}), 32'd0);

    run8(8'h05, 8'h03, 1'b0, 1'b0, lat, nd, nb);
    chk("post_reset_sum", 32'({cout8, ovf8, sum8}), 32'h008);
    chk("post_reset_latency", 32'(lat), 32'(W8));
    chk("post_reset_busy_cycles", 32'(nb), 32'(W8));

    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        for (int k = 0; k < 4; k++) begin
          lanes(a, b, k[0], k[1]);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
